ysyx_25060170_mem_responder: RTL and testbench

- Memory-side responder for the core's fetch/load-store port.
- Accepts one read or write request at a time over a valid/ready request channel and serves it from an internal word array after a fixed, parameterised latency.
- Returns data and error status over a valid/ready response channel.
- Replaces the combinational instruction memory once the IFU/LSU become handshake initiators; it is the slave end of the core's memory interface.

---
 rtl/ysyx_25060170_mem_responder.sv | 136 +++++++++++++
 tb/tb_ysyx_25060170_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_mem_responder.sv
// Memory-side responder: valid/ready request and response channels.
// Each request is served from an internal word array after a fixed latency.
module ysyx_25060170_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;
   localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        addr_q, addr_d;
   logic               wen_q, wen_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         wstrb_q, wstrb_d;
   logic               resp_valid_q, resp_valid_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;

   logic [31:0]        mem [DEPTH_WORDS];
   logic [30:0]        word_off;
   logic [IDX_W-1:0]   idx;
   logic               acc_err;
   logic [31:0]        wmerge;
   logic               mem_we;

   // 31-bit word-offset subtraction: bit 30 flags addresses below BASE_ADDR
   always_comb begin
      word_off = {1'b0, addr_q[31:2]} - {1'b0, BASE_ADDR[31:2]};
      idx      = word_off[IDX_W-1:0];
      acc_err  = (addr_q[1:0] != 2'b00) || word_off[30] || (word_off[29:0] >= DEPTH_L);
      for (int i = 0; i < 4; i++) begin
         wmerge[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : mem[idx][8*i +: 8];
      end
   end

   assign req_ready  = (state_q == S_IDLE) && !rst;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      resp_valid_d = resp_valid_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      mem_we       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               addr_d  = req_addr;
               wen_d   = req_wen;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               resp_valid_d = 1'b1;
               err_d        = acc_err;
               rdata_d      = (!wen_q && !acc_err) ? mem[idx] : 32'h0;
               mem_we       = wen_q && !acc_err;
               state_d      = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               rdata_d      = 32'h0;
               err_d        = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   // Array is not reset; a reset landing on the commit edge drops the write
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[idx] <= wmerge;
      end
   end

endmodule

// File: tb/tb_ysyx_25060170_mem_responder.sv
// Scoreboard bench for ysyx_25060170_mem_responder: three instances at
// latencies 2, 1 and 4 share one expected-response queue and a memory model.
module tb_ysyx_25060170_mem_responder;

   localparam logic [11:0] LATS = {4'd4, 4'd1, 4'd2};

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_wen;
   logic [2:0]  resp_ready;
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_wstrb [3];
   wire  [2:0]  req_ready;
   wire  [2:0]  resp_valid;
   wire  [2:0]  resp_err;
   wire  [31:0] resp_rdata [3];

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb_q[$];
   logic [31:0] model [int unsigned];
   time         accept_t [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ysyx_25060170_mem_responder #(
         .BASE_ADDR  (32'h8000_0000),
         .DEPTH_WORDS(1024),
         .LATENCY    (int'(LATS[g*4 +: 4]))
      ) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_addr  (req_addr[g]),
         .req_wen   (req_wen[g]),
         .req_wdata (req_wdata[g]),
         .req_wstrb (req_wstrb[g]),
         .resp_valid(resp_valid[g]),
         .resp_ready(resp_ready[g]),
         .resp_rdata(resp_rdata[g]),
         .resp_err  (resp_err[g])
      );
   end

   function automatic int unsigned lat_of(int k);
      return int'(LATS[k*4 +: 4]);
   endfunction

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference behaviour: one 4 KiB window at 0x8000_0000, word-aligned only
   function automatic exp_t model_access(int k, logic [31:0] addr, logic wen,
                                         logic [31:0] wd, logic [3:0] ws);
      exp_t           e;
      longint unsigned a;
      int unsigned    key;
      logic [31:0]    w;
      e = '0;
      a = 64'(addr);
      if (addr[1:0] != 2'b00 || a < 64'h8000_0000 || a >= 64'h8000_1000) begin
         e.err = 1'b1;
      end else begin
         key = 32'(k) * 4096 + 32'((a - 64'h8000_0000) / 4);
         w   = model.exists(key) ? model[key] : 32'h0;
         if (wen) begin
            for (int i = 0; i < 4; i++) if (ws[i]) w[8*i +: 8] = wd[8*i +: 8];
            model[key] = w;
         end else begin
            e.rdata = w;
         end
      end
      return e;
   endfunction

   // Entered and left at a negedge with instance k idle.
   task automatic do_req(int k, logic [31:0] addr, logic wen, logic [31:0] wd,
                         logic [3:0] ws, int hold, bit concur);
      exp_t        e;
      int          cyc;
      logic [31:0] rd_s;
      logic        er_s;
      req_addr[k]   = addr;
      req_wen[k]    = wen;
      req_wdata[k]  = wd;
      req_wstrb[k]  = ws;
      req_valid[k]  = 1'b1;
      resp_ready[k] = (hold == 0);
      check_eq("req_ready_idle", 32'(req_ready[k]), 32'd1);
      @(posedge clk);
      accept_t[k] = $time;
      sb_q.push_back(model_access(k, addr, wen, wd, ws));
      @(negedge clk);
      req_valid[k] = 1'b0;
      req_addr[k]  = ~addr;
      req_wdata[k] = ~wd;
      cyc = 1;
      while (!resp_valid[k] && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("latency", 32'(cyc - 1), 32'(lat_of(k)));
      check_eq("req_ready_resp", 32'(req_ready[k]), 32'd0);
      rd_s = resp_rdata[k];
      er_s = resp_err[k];
      if (hold > 0) begin
         if (concur) begin
            req_valid[k] = 1'b1;
            req_addr[k]  = 32'h8000_0010;
            req_wen[k]   = 1'b1;
            req_wdata[k] = 32'hFFFF_FFFF;
            req_wstrb[k] = 4'hF;
         end
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_tests++;
            if (resp_rdata[k] !== rd_s || resp_err[k] !== er_s || resp_valid[k] !== 1'b1
                || req_ready[k] !== 1'b0) begin
               n_fail++;
               $display("FAIL hold_stable: valid=%b ready=%b rdata=%h err=%b, required valid=1 ready=0 rdata=%h err=%b",
                        resp_valid[k], req_ready[k], resp_rdata[k], resp_err[k], rd_s, er_s);
            end
         end
         resp_ready[k] = 1'b1;
      end
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_eq("rdata", resp_rdata[k], e.rdata);
         check_eq("err", 32'(resp_err[k]), 32'(e.err));
      end
      @(negedge clk);
      req_valid[k] = 1'b0;
      check_eq("resp_valid_drop", 32'(resp_valid[k]), 32'd0);
      check_eq("rdata_clear", resp_rdata[k], 32'h0);
      check_eq("err_clear", 32'(resp_err[k]), 32'd0);
      check_eq("req_ready_after", 32'(req_ready[k]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      time  t0;
      logic seen;
      rst        = 3'b111;
      req_valid  = '0;
      req_wen    = '0;
      resp_ready = '0;
      for (int k = 0; k < 3; k++) begin
         req_addr[k]  = '0;
         req_wdata[k] = '0;
         req_wstrb[k] = '0;
      end
      repeat (2) @(negedge clk);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      rst = 3'b000;
      @(negedge clk);
      check_eq("post_rst_ready", 32'(req_ready), 32'h7);
      check_eq("post_rst_rdata", resp_rdata[0], 32'h0);
      check_eq("post_rst_err", 32'(resp_err), 32'd0);

      // Full write, readback, partial write
      do_req(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
      do_req(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      do_req(0, 32'h8000_0010, 1'b1, 32'h1122_3344, 4'b0101, 0, 1'b0);
      do_req(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      // Zero strobe writes nothing
      do_req(0, 32'h8000_0010, 1'b1, 32'h5555_5555, 4'h0, 0, 1'b0);
      do_req(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      // Error cases and window edges
      do_req(0, 32'h8000_0000, 1'b1, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
      do_req(0, 32'h8000_0002, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      do_req(0, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      do_req(0, 32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
      do_req(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      do_req(0, 32'h8000_0FFC, 1'b1, 32'hA5A5_0FFC, 4'hF, 0, 1'b0);
      do_req(0, 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      do_req(0, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      // Backpressure with a competing request, then prove it was dropped
      do_req(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 5, 1'b1);
      do_req(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      do_req(0, 32'h8000_0002, 1'b1, 32'h0, 4'hF, 3, 1'b0);

      // Latency 1 instance: back-to-back every three cycles
      for (int i = 0; i < 4; i++) begin
         do_req(1, 32'h8000_0100 + 32'(i * 4), 1'b1, 32'h1000_0000 + 32'(i * 17), 4'hF, 0, 1'b0);
      end
      do_req(1, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      for (int i = 1; i < 4; i++) begin
         t0 = accept_t[1];
         do_req(1, 32'h8000_0100 + 32'(i * 4), 1'b0, 32'h0, 4'h0, 0, 1'b0);
         check_eq("b2b_gap", 32'((accept_t[1] - t0) / 10), 32'd3);
      end

      // Latency 4 instance: reset two cycles after accept drops the write
      do_req(2, 32'h8000_0020, 1'b1, 32'h1234_5678, 4'hF, 0, 1'b0);
      req_addr[2]   = 32'h8000_0020;
      req_wen[2]    = 1'b1;
      req_wdata[2]  = 32'hCAFE_F00D;
      req_wstrb[2]  = 4'hF;
      req_valid[2]  = 1'b1;
      resp_ready[2] = 1'b1;
      check_eq("abort_ready", 32'(req_ready[2]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      @(negedge clk);
      rst[2] = 1'b1;
      @(negedge clk);
      check_eq("abort_rst_ready", 32'(req_ready[2]), 32'd0);
      rst[2] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen = seen | resp_valid[2];
         @(negedge clk);
      end
      check_eq("abort_no_resp", 32'(seen), 32'd0);
      do_req(2, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      do_req(2, 32'h8000_0024, 1'b1, 32'h0000_BEEF, 4'b0011, 2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
